// File: rtl/ksa_pipe_arbiter.sv
// ksa_pipe_arbiter
// Two requesters share one free-running pipelined 32-bit adder. Requests are
// granted round-robin; subtraction is folded into the operands (~B, cin=1).
// Each issued op carries a small tag down a shadow pipe so its result can be
// pushed into the issuing requester's response FIFO. Because the adder cannot
// stall, issue is credit-limited: a requester may only have as many ops
// in flight plus queued as its FIFO has slots.
module ksa_pipe_arbiter #(
   parameter int LATENCY    = 7,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        req0_valid_in,
   output logic        req0_ready_out,
   input  logic [31:0] req0_a_in,
   input  logic [31:0] req0_b_in,
   input  logic        req0_sub_in,
   input  logic        req1_valid_in,
   output logic        req1_ready_out,
   input  logic [31:0] req1_a_in,
   input  logic [31:0] req1_b_in,
   input  logic        req1_sub_in,
   output logic        rsp0_valid_out,
   input  logic        rsp0_ready_in,
   output logic [31:0] rsp0_sum_out,
   output logic        rsp0_cout_out,
   output logic        rsp0_ovf_out,
   output logic        rsp1_valid_out,
   input  logic        rsp1_ready_in,
   output logic [31:0] rsp1_sum_out,
   output logic        rsp1_cout_out,
   output logic        rsp1_ovf_out,
   output logic        add_valid_out,
   output logic [31:0] add_a_out,
   output logic [31:0] add_b_out,
   output logic        add_cin_out,
   input  logic [31:0] add_sum_in,
   input  logic        add_cout_in
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   // Tag stage k holds the op whose operands left the output registers k cycles ago;
   // the last stage lines up with add_sum_in.
   localparam int TD = LATENCY + 1;

   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [1:0]    issue;
   logic [1:0]    rsp_valid;
   logic [1:0]    rsp_ready;
   logic [1:0]    pop;
   logic [1:0]    push;
   logic [33:0]   rsp_data [2];   // {sum, cout, ovf}

   logic          ptr_reg;
   logic          ptr_next;
   logic [CW-1:0] cred_reg [2];

   logic          add_valid_reg;
   logic [31:0]   add_a_reg;
   logic [31:0]   add_b_reg;
   logic          add_cin_reg;

   logic [TD-1:0] tag_valid_reg;
   logic [TD-1:0] tag_id_reg;
   logic [TD-1:0] tag_a31_reg;
   logic [TD-1:0] tag_b31_reg;

   logic          issue_any;
   logic [31:0]   sel_a;
   logic [31:0]   sel_b;
   logic          sel_sub;
   logic          retire_valid;
   logic          retire_id;
   logic          retire_ovf;

   assign req_valid = {req1_valid_in, req0_valid_in};
   assign rsp_ready = {rsp1_ready_in, rsp0_ready_in};

   // At most one side is ready when both are valid and both have credit,
   // so issue[1:0] is one-hot or zero and issue[1] doubles as the issue id.
   assign issue_any = |issue;
   assign sel_a     = issue[1] ? req1_a_in   : req0_a_in;
   assign sel_sub   = issue[1] ? req1_sub_in : req0_sub_in;
   assign sel_b     = (issue[1] ? req1_b_in : req0_b_in) ^ {32{sel_sub}};

   assign retire_valid = tag_valid_reg[TD-1];
   assign retire_id    = tag_id_reg[TD-1];
   // Signed overflow: operands agree in sign but the sum does not.
   assign retire_ovf   = (tag_a31_reg[TD-1] ~^ tag_b31_reg[TD-1])
                       & (add_sum_in[31] ^ tag_a31_reg[TD-1]);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         logic [33:0] fifo_mem [FIFO_DEPTH];
         logic [PW:0] wr_ptr_reg;
         logic [PW:0] rd_ptr_reg;

         // The other side only blocks us when it is valid, has credit and owns the pointer.
         assign req_ready[gi] = !rst_in && (cred_reg[gi] != '0)
                              && ((ptr_reg == 1'(gi)) || !req_valid[1-gi]
                                  || (cred_reg[1-gi] == '0));
         assign issue[gi]     = req_valid[gi] & req_ready[gi];
         assign push[gi]      = retire_valid && (retire_id == 1'(gi));
         assign rsp_valid[gi] = (wr_ptr_reg != rd_ptr_reg);
         assign pop[gi]       = rsp_valid[gi] & rsp_ready[gi];
         assign rsp_data[gi]  = fifo_mem[rd_ptr_reg[PW-1:0]];

         // Response storage; credits guarantee a slot is free whenever a result retires.
         always_ff @(posedge clk_in) begin
            if (push[gi]) begin
               fifo_mem[wr_ptr_reg[PW-1:0]] <= {add_sum_in, add_cout_in, retire_ovf};
            end
         end

         // FIFO pointers with a wrap bit to tell full from empty.
         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
            end else begin
               if (push[gi]) wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
               if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
            end
         end
      end
   endgenerate

   // Round-robin pointer moves to the other side after each grant.
   always_comb begin
      ptr_next = ptr_reg;
      if (issue[0])      ptr_next = 1'b1;
      else if (issue[1]) ptr_next = 1'b0;
   end

   // Pointer register.
   always_ff @(posedge clk_in) begin
      if (rst_in) ptr_reg <= 1'b0;
      else        ptr_reg <= ptr_next;
   end

   // Credits: free slots counting both in-flight ops and queued results per side.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < 2; i++) cred_reg[i] <= CW'(FIFO_DEPTH);
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (issue[i] && !pop[i])      cred_reg[i] <= cred_reg[i] - CW'(1);
            else if (pop[i] && !issue[i]) cred_reg[i] <= cred_reg[i] + CW'(1);
         end
      end
   end

   // Operand registers feeding the adder; valid pulses for exactly one cycle per issue.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         add_valid_reg <= 1'b0;
         add_a_reg     <= '0;
         add_b_reg     <= '0;
         add_cin_reg   <= 1'b0;
      end else begin
         add_valid_reg <= issue_any;
         if (issue_any) begin
            add_a_reg   <= sel_a;
            add_b_reg   <= sel_b;
            add_cin_reg <= sel_sub;
         end
      end
   end

   // Tag shadow pipe tracking owner and operand signs alongside the adder.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tag_valid_reg <= '0;
         tag_id_reg    <= '0;
         tag_a31_reg   <= '0;
         tag_b31_reg   <= '0;
      end else begin
         tag_valid_reg <= {tag_valid_reg[TD-2:0], issue_any};
         tag_id_reg    <= {tag_id_reg[TD-2:0],    issue[1]};
         tag_a31_reg   <= {tag_a31_reg[TD-2:0],   sel_a[31]};
         tag_b31_reg   <= {tag_b31_reg[TD-2:0],   sel_b[31]};
      end
   end

   assign req0_ready_out = req_ready[0];
   assign req1_ready_out = req_ready[1];

   assign rsp0_valid_out = rsp_valid[0];
   assign rsp0_sum_out   = rsp_data[0][33:2];
   assign rsp0_cout_out  = rsp_data[0][1];
   assign rsp0_ovf_out   = rsp_data[0][0];
   assign rsp1_valid_out = rsp_valid[1];
   assign rsp1_sum_out   = rsp_data[1][33:2];
   assign rsp1_cout_out  = rsp_data[1][1];
   assign rsp1_ovf_out   = rsp_data[1][0];

   assign add_valid_out = add_valid_reg;
   assign add_a_out     = add_a_reg;
   assign add_b_out     = add_b_reg;
   assign add_cin_out   = add_cin_reg;

endmodule
